alu_wb_buffer: RTL and testbench
================================

Name: alu_wb_buffer

Overview:
- Downstream neighbour of the ALU. Captures each ALU result (64-bit {C_hi, C_lo}, zero/neg flags, control code, destination register) in a small FIFO.
- Drains results to the register-file writeback port over a valid/ready handshake.
- Narrow ops write one GPR beat. DIV/MUL results are split into two beats: LO first, then HI.
- Holds the architectural condition flags, updated when each result retires.

Parameters:
- DEPTH, 2, FIFO entries (≥1, not restricted to powers of 2)
- REG_W, 4, destination register address width
- CTRL_W, 4, ALU control code width
- CTRL_DIV, 4'd5, control code marking a divide result (top level overrides with ALU constant)
- CTRL_MUL, 4'd6, control code marking a multiply result (top level overrides with ALU constant)

Ports:
- iClk  in  1  clock, rising edge
- iRst  in  1  reset, asynchronous, active-high
- iValid  in  1  ALU result valid
- oReady  out  1  buffer can accept
- iC  in  64  ALU result {C_hi, C_lo}
- iZero  in  1  ALU zero flag
- iNeg  in  1  ALU negative flag
- iCtrl  in  CTRL_W  ALU control code of this result
- iRd  in  REG_W  destination GPR
- oWbValid  out  1  writeback beat valid
- iWbReady  in  1  register file accepts beat
- oWbData  out  32  writeback data
- oWbAddr  out  REG_W  GPR address (0 on HI/LO beats)
- oWbDest  out  2  00 GPR, 01 LO, 10 HI
- oZeroF  out  1  retired zero flag
- oNegF  out  1  retired negative flag
- oCount  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (async, any time, including mid-beat):
  - FIFO pointers and count cleared; FSM to IDLE.
  - oWbValid=0, oWbData=0, oWbAddr=0, oWbDest=0, oZeroF=0, oNegF=0, oCount=0, oReady=1.
  - In-flight entries are discarded; no residual beats after reset.
- Push: iValid && oReady stores {iC, iZero, iNeg, wide=(iCtrl==CTRL_DIV || iCtrl==CTRL_MUL), isdiv, iRd}. iValid while oReady=0 is ignored.
- oReady = (oCount < DEPTH). It has no combinational dependence on iWbReady (see Optional Feature).
- Pointers advance modulo DEPTH with explicit wrap at DEPTH-1.
- Latency: entry pushed at edge N is presented (oWbValid=1) after edge N+1.
- Output FSM:
  - IDLE: oWbValid=0. Goes to BEAT0 when count>0.
  - BEAT0: head entry presented.
    - Narrow entry: data=C[31:0], dest GPR, addr=rd.
    - Wide entry, LO beat:
      - MUL: LO←C[31:0].
      - DIV: LO←C[63:32] (quotient).
    - On handshake:
      - Narrow: pop, update flags, go to BEAT0 if more entries remain, else IDLE.
      - Wide: go to BEAT1.
  - BEAT1 (wide only): HI beat.
    - MUL: HI←C[63:32].
    - DIV: HI←C[31:0] (remainder).
    - On handshake: pop, update flags, go to BEAT0 or IDLE.
- oWbValid and all beat outputs are registered and held stable until iWbReady. Beats are never dropped or repeated.
- Flags: oZeroF/oNegF load the entry's stored iZero/iNeg on the final beat handshake only.
- Simultaneous push and final-beat pop: count unchanged, both pointers advance.
- Push when empty and no pop: count 0→1.
- Full with a pop in progress: push refused that cycle (oReady already 0).
- Ordering is strictly FIFO. Beats of two entries never interleave.

Optional Feature:
- Macro ALU_WB_BYPASS_EN.
- Defined: oReady = (oCount < DEPTH) || (oWbValid && iWbReady && final beat). A full buffer accepts a new result in the same cycle its head retires; count stays DEPTH. This path is combinational from iWbReady.
- Undefined: oReady = (oCount < DEPTH) only, so a full buffer loses one cycle before accepting again.

Test Plan:
- Reset: assert iRst mid-run → oWbValid=0, oCount=0, oReady=1, oZeroF=oNegF=0 asynchronously, before the next clock.
- ADD: iC=64'h0000_0000_0000_0003, iRd=5, iZero=0, iNeg=0, iWbReady=1 → one cycle after push: oWbData=3, oWbAddr=5, oWbDest=00; exactly one beat; then oZeroF=0.
- DIV: iC={32'd2, 32'd1}, iCtrl=CTRL_DIV → beat 1 oWbDest=01, data 2; beat 2 oWbDest=10, data 1; flags update only after beat 2.
- Backpressure: iWbReady=0, push three narrow results (data 10, 20, 30) → third refused, oCount=2, oReady=0. Release iWbReady → outputs 10 then 20, oCount 2→1→0.
- Count=1 with a narrow push and final pop in the same cycle → oCount stays 1; the new entry is presented next.
- Reset after the LO beat of a MUL (iC=64'hFFFF_FFFF_0000_0001) → no HI beat ever appears.
  - ALU_WB_BYPASS_EN defined: full buffer, iWbReady=1, iValid=1 → oReady=1 that cycle and oCount stays 2.
  - ALU_WB_BYPASS_EN undefined: same stimulus → push refused that cycle.

Source files
------------

// File: rtl/alu_wb_buffer.sv
// alu_wb_buffer: FIFO of ALU results drained as GPR / LO+HI writeback beats
// Ports: iClk/iRst (async, active-high); iValid/oReady + iC/iZero/iNeg/iCtrl/iRd push side;
//        oWbValid/iWbReady + oWbData/oWbAddr/oWbDest writeback side; oZeroF/oNegF retired flags;
//        oCount occupancy. Macro ALU_WB_BYPASS_EN lets a full buffer accept while its head retires.
module alu_wb_buffer #(
  parameter int DEPTH = 2,
  parameter int REG_W = 4,
  parameter int CTRL_W = 4,
  parameter logic [CTRL_W-1:0] CTRL_DIV = 4'd5,
  parameter logic [CTRL_W-1:0] CTRL_MUL = 4'd6
) (
  input  logic                         iClk,
  input  logic                         iRst,
  input  logic                         iValid,
  output logic                         oReady,
  input  logic [63:0]                  iC,
  input  logic                         iZero,
  input  logic                         iNeg,
  input  logic [CTRL_W-1:0]            iCtrl,
  input  logic [REG_W-1:0]             iRd,
  output logic                         oWbValid,
  input  logic                         iWbReady,
  output logic [31:0]                  oWbData,
  output logic [REG_W-1:0]             oWbAddr,
  output logic [1:0]                   oWbDest,
  output logic                         oZeroF,
  output logic                         oNegF,
  output logic [$clog2(DEPTH+1)-1:0]   oCount
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
  typedef struct packed {
    logic [63:0]      c;
    logic             z;
    logic             n;
    logic             wide;
    logic             div;
    logic [REG_W-1:0] rd;
  } entry_t;
  entry_t mem [DEPTH];
  entry_t head, ld;
  state_t state_q, state_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, rd_nxt, wr_nxt;
  logic [CW-1:0] count_q, count_d;
  logic valid_q, valid_d, zf_q, zf_d, nf_q, nf_d;
  logic [31:0] data_q, data_d;
  logic [REG_W-1:0] addr_q, addr_d;
  logic [1:0] dest_q, dest_d;
  logic hs, last, push, ld_hi, ld_new;
  assign head   = mem[rd_q];
  assign rd_nxt = (rd_q == PW'(DEPTH-1)) ? '0 : rd_q + 1'b1;
  assign wr_nxt = (wr_q == PW'(DEPTH-1)) ? '0 : wr_q + 1'b1;
  assign hs     = valid_q & iWbReady;
  // The final beat of an entry is the only one that pops it and retires its flags.
  assign last   = hs & (state_q == BEAT1 | ~head.wide);
`ifdef ALU_WB_BYPASS_EN
  assign oReady = (count_q < CW'(DEPTH)) | last;
`else
  assign oReady = count_q < CW'(DEPTH);
`endif
  assign push   = iValid & oReady;
  always_comb begin
    count_d = count_q + CW'(push) - CW'(last);
    wr_d    = push ? wr_nxt : wr_q;
    rd_d    = last ? rd_nxt : rd_q;
    zf_d    = last ? head.z : zf_q;
    nf_d    = last ? head.n : nf_q;
    ld_hi   = state_q == BEAT0 & hs & head.wide;
    // A retiring entry hands straight over to the next only if it was already stored;
    // an entry pushed this same cycle goes through IDLE to keep the fixed push latency.
    ld_new  = (state_q == IDLE & count_q != '0) | (last & count_q > CW'(1));
    ld      = (state_q == IDLE | ld_hi) ? head : mem[rd_nxt];
    state_d = ld_hi ? BEAT1 : ld_new ? BEAT0 : last ? IDLE : state_q;
    valid_d = ld_hi | ld_new | (valid_q & ~hs);
    data_d  = ld_hi ? (ld.div ? ld.c[31:0] : ld.c[63:32]) :
              ld_new ? ((ld.wide & ld.div) ? ld.c[63:32] : ld.c[31:0]) :
              hs ? '0 : data_q;
    addr_d  = ld_hi ? '0 : ld_new ? (ld.wide ? '0 : ld.rd) : hs ? '0 : addr_q;
    dest_d  = ld_hi ? 2'b10 : ld_new ? (ld.wide ? 2'b01 : 2'b00) : hs ? 2'b00 : dest_q;
  end
  always_ff @(posedge iClk)
    if (push) mem[wr_q] <= {iC, iZero, iNeg, iCtrl == CTRL_DIV || iCtrl == CTRL_MUL, iCtrl == CTRL_DIV, iRd};
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      dest_q  <= '0;
      zf_q    <= 1'b0;
      nf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      dest_q  <= dest_d;
      zf_q    <= zf_d;
      nf_q    <= nf_d;
    end
  end
  assign oWbValid = valid_q;
  assign oWbData  = data_q;
  assign oWbAddr  = addr_q;
  assign oWbDest  = dest_q;
  assign oZeroF   = zf_q;
  assign oNegF    = nf_q;
  assign oCount   = count_q;
endmodule

// File: tb/tb_alu_wb_buffer.sv
// tb_alu_wb_buffer: random and directed stimulus against a beat-queue reference model
module tb_alu_wb_buffer;
  localparam int DEPTH = 2;
  typedef struct {
    logic [31:0] data;
    logic [3:0]  addr;
    logic [1:0]  dest;
    logic        fin, z, n;
  } beat_t;
  logic clk = 0, rst = 0;
  logic i_valid = 0, i_zero = 0, i_neg = 0, wb_ready = 0;
  logic [63:0] i_c = '0;
  logic [3:0] i_ctrl = '0, i_rd = '0;
  logic o_ready, wb_valid, zero_f, neg_f;
  logic [31:0] wb_data;
  logic [3:0] wb_addr;
  logic [1:0] wb_dest, o_count;
  beat_t exp_q[$];
  int cnt = 0, idle = 0, checks = 0, errors = 0;
  logic zf = 0, nf = 0;
  always #5 clk = ~clk;
  alu_wb_buffer #(.DEPTH(DEPTH)) dut (
    .iClk(clk), .iRst(rst), .iValid(i_valid), .oReady(o_ready), .iC(i_c),
    .iZero(i_zero), .iNeg(i_neg), .iCtrl(i_ctrl), .iRd(i_rd),
    .oWbValid(wb_valid), .iWbReady(wb_ready), .oWbData(wb_data), .oWbAddr(wb_addr),
    .oWbDest(wb_dest), .oZeroF(zero_f), .oNegF(neg_f), .oCount(o_count)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    i_valid = 0;
    wb_ready = 0;
    #2 rst = 1;
    #1;
    check("rst_valid", wb_valid, 0);
    check("rst_count", o_count, 0);
    check("rst_ready", o_ready, 1);
    check("rst_zf", zero_f, 0);
    check("rst_nf", neg_f, 0);
    check("rst_data", wb_data, 0);
    check("rst_addr", wb_addr, 0);
    check("rst_dest", wb_dest, 0);
    exp_q.delete();
    cnt = 0; zf = 0; nf = 0; idle = 0;
    @(negedge clk);
    rst = 0;
  endtask
  task automatic step(input logic v, input logic [63:0] c, input logic z, input logic n,
                      input logic [3:0] ctrl, input logic [3:0] rd, input logic wr);
    logic hs, fin, rdy;
    beat_t b;
    @(negedge clk);
    i_valid = v; i_c = c; i_zero = z; i_neg = n; i_ctrl = ctrl; i_rd = rd; wb_ready = wr;
    #1;
    fin = 0;
    hs = 0;
    if (wb_valid) begin
      idle = 0;
      if (exp_q.size() == 0) check("spurious_valid", wb_valid, 0);
      else begin
        b = exp_q[0];
        check("wb_data", wb_data, b.data);
        check("wb_addr", wb_addr, b.addr);
        check("wb_dest", wb_dest, b.dest);
        fin = b.fin;
        hs = wr;
      end
    end else if (exp_q.size() != 0) begin
      idle++;
      if (idle > 1) check("latency", wb_valid, 1);
    end
    check("count", o_count, cnt);
    check("zero_f", zero_f, zf);
    check("neg_f", neg_f, nf);
`ifdef ALU_WB_BYPASS_EN
    rdy = (cnt < DEPTH) || (hs && fin);
`else
    rdy = cnt < DEPTH;
`endif
    check("ready", o_ready, rdy);
    if (hs) begin
      if (fin) begin zf = b.z; nf = b.n; cnt--; end
      void'(exp_q.pop_front());
    end
    if (v && rdy) begin
      cnt++;
      if (ctrl == 4'd6) begin
        exp_q.push_back('{c[31:0], 4'd0, 2'b01, 1'b0, z, n});
        exp_q.push_back('{c[63:32], 4'd0, 2'b10, 1'b1, z, n});
      end else if (ctrl == 4'd5) begin
        exp_q.push_back('{c[63:32], 4'd0, 2'b01, 1'b0, z, n});
        exp_q.push_back('{c[31:0], 4'd0, 2'b10, 1'b1, z, n});
      end else exp_q.push_back('{c[31:0], rd, 2'b00, 1'b1, z, n});
    end
  endtask
  task automatic idle_step(input logic wr);
    step(0, 64'h0, 0, 0, 4'd0, 4'd0, wr);
  endtask
  initial begin
    do_reset();
    step(1, 64'h3, 0, 0, 4'd0, 4'd5, 1);
    idle_step(1);
    check("add_bubble", wb_valid, 0);
    idle_step(1);
    check("add_valid", wb_valid, 1);
    check("add_data", wb_data, 3);
    check("add_addr", wb_addr, 5);
    check("add_dest", wb_dest, 0);
    idle_step(1);
    check("add_once", wb_valid, 0);
    check("add_zf", zero_f, 0);
    step(1, {32'd2, 32'd1}, 1, 1, 4'd5, 4'd3, 1);
    idle_step(1);
    idle_step(1);
    check("div_lo_dest", wb_dest, 2'b01);
    check("div_lo_data", wb_data, 2);
    idle_step(1);
    check("div_hi_dest", wb_dest, 2'b10);
    check("div_hi_data", wb_data, 1);
    check("div_zf_hold", zero_f, 0);
    idle_step(1);
    check("div_zf", zero_f, 1);
    check("div_nf", neg_f, 1);
    do_reset();
    step(1, 64'd10, 0, 0, 4'd0, 4'd1, 0);
    step(1, 64'd20, 0, 0, 4'd0, 4'd2, 0);
    step(1, 64'd30, 0, 0, 4'd0, 4'd3, 0);
    check("bp_ready", o_ready, 0);
    check("bp_count", o_count, 2);
    idle_step(1);
    check("bp_first", wb_data, 10);
    idle_step(1);
    check("bp_second", wb_data, 20);
    check("bp_count1", o_count, 1);
    idle_step(1);
    check("bp_count0", o_count, 0);
    check("bp_no_third", wb_valid, 0);
    do_reset();
    step(1, 64'h11, 0, 0, 4'd0, 4'd1, 1);
    idle_step(1);
    step(1, 64'h22, 1, 0, 4'd0, 4'd2, 1);
    idle_step(1);
    check("c1_count", o_count, 1);
    idle_step(1);
    check("c1_next", wb_data, 32'h22);
    do_reset();
    step(1, 64'hFFFF_FFFF_0000_0001, 0, 1, 4'd6, 4'd7, 0);
    idle_step(0);
    idle_step(0);
    check("mul_lo_dest", wb_dest, 2'b01);
    check("mul_lo_data", wb_data, 1);
    idle_step(1);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle_step(1);
      check("mul_no_hi", wb_valid, 0);
    end
    check("mul_nf", neg_f, 0);
    do_reset();
    step(1, 64'h41, 0, 0, 4'd0, 4'd1, 0);
    step(1, 64'h42, 0, 0, 4'd0, 4'd2, 0);
    idle_step(0);
    step(1, 64'h43, 0, 0, 4'd0, 4'd3, 1);
`ifdef ALU_WB_BYPASS_EN
    check("full_ready", o_ready, 1);
`else
    check("full_ready", o_ready, 0);
`endif
    idle_step(0);
`ifdef ALU_WB_BYPASS_EN
    check("full_count", o_count, 2);
`else
    check("full_count", o_count, 1);
`endif
    for (int i = 0; i < 10; i++) idle_step(1);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 2) != 0, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
           4'($urandom_range(0, 7)), 4'($urandom), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 20; i++) idle_step(1);
    check("drain_count", o_count, 0);
    check("drain_model", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
